approx_add_pipe: RTL and testbench
==================================

Name: approx_add_pipe

Overview:
- Parametrised W-bit approximate adder with a runtime-selectable approximation depth k, where the lower k bits use a lower-part-OR scheme.
- Two-stage valid/ready pipeline; an exact reference sum is computed alongside every approximate result.
- An on-line error monitor accumulates error statistics for accuracy characterisation.
- Successor to the fixed 8-bit approximate adders; used in approximate datapaths and accuracy sweeps.

Parameters:
- W, 8, operand width; sum and exact are W+1 bits.
- KMAX, 4, maximum approximated LSB count; 0 <= KMAX <= W-1.
- K_W, 3, width of k port; must hold KMAX.
- CNT_W, 16, width of transaction and error counters.
- ACC_W, 24, width of absolute-error accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat.
- a  in  W  operand A.
- b  in  W  operand B.
- k  in  K_W  approximated LSB count, sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  W+1  approximate sum.
- exact  out  W+1  exact a+b.
- err_flag  out  1  sum != exact for the current result.
- stat_clr  in  1  synchronous clear of all statistics.
- stat_cnt  out  CNT_W  completed transactions.
- stat_err_cnt  out  CNT_W  transactions with err_flag=1.
- stat_abs_err  out  ACC_W  sum of |sum-exact|.
- stat_max_err  out  W+1  maximum |sum-exact| seen.

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline valids=0; sum, exact, err_flag and all stat_* =0.
- in_ready=1 is permitted during reset.
- Global advance enable: en = ~out_valid | out_ready. in_ready = en, combinational.
- When en=1, stage 1 captures a, b, keff and in_valid; stage 2 captures the stage-1 results and valid.
- When en=0, all registers hold. sum, exact and err_flag remain stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from accepted input to out_valid when out_ready=1. Throughput: 1 result/cycle.
- keff = min(k, KMAX), latched in stage 1.
- Approximate sum (computed in stage 2):
  - For i < keff: sum[i] = a[i] | b[i].
  - Carry into bit keff: cin = a[keff-1] & b[keff-1] if keff > 0, else 0.
  - sum[W:keff] = a[W-1:keff] + b[W-1:keff] + cin, exact with carry-out.
  - keff=0 gives an exact adder.
- exact = a + b (W+1 bits). err = |sum - exact| (W+1 bits). err_flag = (err != 0).
- Statistics update on output handshake (out_valid & out_ready):
  - stat_cnt +1.
  - stat_err_cnt +1 if err_flag.
  - stat_abs_err += err.
  - stat_max_err = max(stat_max_err, err).
- All counters and the accumulator saturate at all-ones and never wrap.
- stat_clr=1: all stat_* go to 0 on the next edge. It takes priority over a simultaneous handshake, so that transaction is not counted. The pipeline is unaffected.
- Reset mid-operation: in-flight beats are discarded, and statistics are cleared.
- Bubbles (in_valid=0 while en=1) propagate as out_valid=0 and never update statistics.

Test Plan:
- k=0, a=200, b=100, out_ready=1 -> 2 cycles later sum=300, exact=300, err_flag=0; stat_cnt=1, stat_err_cnt=0.
- k=4, a=0x0F, b=0x01 -> sum=15, exact=16, err_flag=1; stat_abs_err=1, stat_max_err=1. Then k=2, a=3, b=3 -> sum=7, exact=6; stat_abs_err=2, stat_max_err=1.
- k=7 with KMAX=4, a=0x0F, b=0x01 -> clamped to keff=4, sum=15, identical to the k=4 case.
- Backpressure:
  - Stream 4 beats, hold out_ready=0 for 3 cycles once out_valid=1 -> in_ready=0, sum stable.
  - Release out_ready -> all 4 results delivered in order, none dropped or duplicated; stat_cnt=4.
- CNT_W=4, 20 erroring transactions -> stat_cnt=15 and stat_err_cnt=15, saturated. stat_clr asserted on the same cycle as a handshake -> all stats=0 next cycle.
- Assert rst_n=0 asynchronously between clock edges with 2 beats in flight -> out_valid=0 immediately and all stats=0. After release, the next beat produces its result in 2 cycles.

Source files
------------

// File: rtl/approx_add_pipe.sv
// Two-stage W-bit lower-part-OR approximate adder with a runtime approximation depth,
// an exact reference sum alongside each result, and saturating on-line error statistics.
module approx_add_pipe #(
  parameter int W     = 8,
  parameter int KMAX  = 4,
  parameter int K_W   = 3,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [K_W-1:0]   k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       sum,
  output logic [W:0]       exact,
  output logic             err_flag,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_cnt,
  output logic [CNT_W-1:0] stat_err_cnt,
  output logic [ACC_W-1:0] stat_abs_err,
  output logic [W:0]       stat_max_err
);

  logic             en_s;
  logic [K_W-1:0]   keff_s;
  logic             s1_valid_r;
  logic [W-1:0]     s1_a_r;
  logic [W-1:0]     s1_b_r;
  logic [K_W-1:0]   s1_keff_r;
  logic [W-1:0]     mask_s;
  logic [W-1:0]     and_s;
  logic             cin_s;
  logic [W:0]       hi_s;
  logic [W:0]       approx_s;
  logic [W:0]       exact_s;
  logic [W:0]       err_s;
  logic [W:0]       err_r;
  logic             handshake_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] err_cnt_nxt_s;
  logic [ACC_W:0]   acc_sum_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [W:0]       max_nxt_s;

  // The whole pipeline advances together whenever the output slot is free or draining.
  assign en_s        = ~out_valid | out_ready;
  assign in_ready    = en_s;
  assign handshake_s = out_valid & out_ready;

  // Clamp the requested approximation depth to the supported maximum.
  always_comb begin
    if (k < K_W'(KMAX)) begin
      keff_s = k;
    end else begin
      keff_s = K_W'(KMAX);
    end
  end

  // Stage 1: capture operands, effective depth and beat valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_keff_r  <= '0;
    end else if (en_s) begin
      s1_valid_r <= in_valid;
      s1_a_r     <= a;
      s1_b_r     <= b;
      s1_keff_r  <= keff_s;
    end
  end

  // Approximate and exact sums: OR in the low keff bits, carry-in generated from bit keff-1.
  always_comb begin
    mask_s = '0;
    cin_s  = 1'b0;
    and_s  = s1_a_r & s1_b_r;
    for (int i = 0; i < W; i++) begin
      mask_s[i] = (i < int'(s1_keff_r));
      cin_s     = cin_s | (and_s[i] & ((i + 1) == int'(s1_keff_r)));
    end
    hi_s     = {1'b0, s1_a_r >> s1_keff_r} + {1'b0, s1_b_r >> s1_keff_r}
             + {{W{1'b0}}, cin_s};
    approx_s = (hi_s << s1_keff_r) | {1'b0, (s1_a_r | s1_b_r) & mask_s};
    exact_s  = {1'b0, s1_a_r} + {1'b0, s1_b_r};
    if (approx_s >= exact_s) begin
      err_s = approx_s - exact_s;
    end else begin
      err_s = exact_s - approx_s;
    end
  end

  // Stage 2: registered results, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      exact     <= '0;
      err_flag  <= 1'b0;
      err_r     <= '0;
    end else if (en_s) begin
      out_valid <= s1_valid_r;
      sum       <= approx_s;
      exact     <= exact_s;
      err_flag  <= (err_s != '0);
      err_r     <= err_s;
    end
  end

  // Saturating next values for the statistics registers.
  always_comb begin
    if (stat_cnt == '1) begin
      cnt_nxt_s = stat_cnt;
    end else begin
      cnt_nxt_s = stat_cnt + CNT_W'(1);
    end
    if ((stat_err_cnt == '1) || !err_flag) begin
      err_cnt_nxt_s = stat_err_cnt;
    end else begin
      err_cnt_nxt_s = stat_err_cnt + CNT_W'(1);
    end
    acc_sum_s = {1'b0, stat_abs_err} + {1'b0, ACC_W'(err_r)};
    if (acc_sum_s[ACC_W]) begin
      acc_nxt_s = '1;
    end else begin
      acc_nxt_s = acc_sum_s[ACC_W-1:0];
    end
    if (err_r > stat_max_err) begin
      max_nxt_s = err_r;
    end else begin
      max_nxt_s = stat_max_err;
    end
  end

  // Statistics: clear wins over a same-cycle handshake; bubbles never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt     <= '0;
      stat_err_cnt <= '0;
      stat_abs_err <= '0;
      stat_max_err <= '0;
    end else if (stat_clr) begin
      stat_cnt     <= '0;
      stat_err_cnt <= '0;
      stat_abs_err <= '0;
      stat_max_err <= '0;
    end else if (handshake_s) begin
      stat_cnt     <= cnt_nxt_s;
      stat_err_cnt <= err_cnt_nxt_s;
      stat_abs_err <= acc_nxt_s;
      stat_max_err <= max_nxt_s;
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe: hand-computed sums, backpressure ordering,
// counter saturation (CNT_W=4), clear priority and asynchronous reset mid-stream.
module tb_approx_add_pipe;
  localparam int W     = 8;
  localparam int KMAX  = 4;
  localparam int K_W   = 3;
  localparam int CNT_W = 4;
  localparam int ACC_W = 24;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [K_W-1:0]   k;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       sum;
  logic [W:0]       exact;
  logic             err_flag;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_cnt;
  logic [CNT_W-1:0] stat_err_cnt;
  logic [ACC_W-1:0] stat_abs_err;
  logic [W:0]       stat_max_err;

  int n_checks = 0;
  int n_errors = 0;

  approx_add_pipe #(.W(W), .KMAX(KMAX), .K_W(K_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .k(k), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .exact(exact), .err_flag(err_flag), .stat_clr(stat_clr),
    .stat_cnt(stat_cnt), .stat_err_cnt(stat_err_cnt),
    .stat_abs_err(stat_abs_err), .stat_max_err(stat_max_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_stats(input string tag, input int c, input int e, input int s, input int m);
    check({tag, "_cnt"}, 32'(stat_cnt), c);
    check({tag, "_err_cnt"}, 32'(stat_err_cnt), e);
    check({tag, "_abs"}, 32'(stat_abs_err), s);
    check({tag, "_max"}, 32'(stat_max_err), m);
  endtask

  // One beat with out_ready=1: accept, latency check, result check, handshake.
  task automatic run_beat(input string tag, input int ta, input int tb, input int tk,
                          input int es, input int ee, input int ef);
    in_valid = 1'b1; a = 8'(ta); b = 8'(tb); k = 3'(tk);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_sum"}, 32'(sum), es);
    check({tag, "_exact"}, 32'(exact), ee);
    check({tag, "_flag"}, 32'(err_flag), ef);
    tick();
    check({tag, "_drain"}, 32'(out_valid), 0);
  endtask

  int bp_a [4] = '{10, 15, 3, 255};
  int bp_b [4] = '{20, 1, 3, 1};
  int bp_k [4] = '{0, 4, 2, 0};
  int bp_s [4] = '{30, 15, 7, 256};
  int bp_e [4] = '{30, 16, 6, 256};

  initial begin
    int sent;
    int got;
    int stalls;
    logic fire_in;
    logic fire_out;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; k = '0;
    out_ready = 1'b1; stat_clr = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check_stats("rst", 0, 0, 0, 0);
    #11;
    rst_n = 1'b1;
    tick();

    run_beat("exact_k0", 200, 100, 0, 300, 300, 0);
    check_stats("s1", 1, 0, 0, 0);
    run_beat("k4", 15, 1, 4, 15, 16, 1);
    check_stats("s2", 2, 1, 1, 1);
    run_beat("k2", 3, 3, 2, 7, 6, 1);
    check_stats("s3", 3, 2, 2, 1);
    run_beat("k7_clamp", 15, 1, 7, 15, 16, 1);
    check_stats("s4", 4, 3, 3, 1);
    run_beat("k4_big", 6, 6, 4, 6, 12, 1);
    check_stats("s5", 5, 4, 9, 6);
    run_beat("k0_carry", 255, 255, 0, 510, 510, 0);
    check_stats("s6", 6, 4, 9, 6);

    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_stats("clr", 0, 0, 0, 0);

    // Backpressure: 4 beats, 3-cycle stall once the first result appears.
    sent = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (out_valid && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 4);
      if (sent < 4) begin
        a = 8'(bp_a[sent]); b = 8'(bp_b[sent]); k = 3'(bp_k[sent]);
      end
      #1;
      if (out_valid && !out_ready) begin
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_hold_sum", 32'(sum), bp_s[got]);
      end
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        check("bp_sum", 32'(sum), bp_s[got]);
        check("bp_exact", 32'(exact), bp_e[got]);
        got++;
      end
      @(posedge clk);
      if (fire_in) sent++;
      #2;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_delivered", got, 4);
    check("bp_stalls", stalls, 3);
    check_stats("bp", 4, 2, 2, 1);
    tick();
    check("bp_no_dup", 32'(out_valid), 0);

    // Saturation with CNT_W=4: 20 erroring beats back to back.
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    in_valid = 1'b1; a = 8'h0F; b = 8'h01; k = 3'd4;
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check_stats("sat", 15, 15, 20, 1);

    // Clear coincident with a handshake: the transaction is not counted.
    in_valid = 1'b1; a = 8'h0F; b = 8'h01; k = 3'd4;
    tick();
    in_valid = 1'b0;
    tick();
    check("clrhs_valid", 32'(out_valid), 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_stats("clrhs", 0, 0, 0, 0);
    check("clrhs_drain", 32'(out_valid), 0);

    // Asynchronous reset between edges with two beats in flight.
    run_beat("pre_rst", 10, 20, 0, 30, 30, 0);
    check("pre_rst_cnt", 32'(stat_cnt), 1);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd1; b = 8'd2; k = 3'd0;
    tick();
    a = 8'd3; b = 8'd4;
    tick();
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_sum", 32'(sum), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check_stats("arst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_empty", 32'(out_valid), 0);
    run_beat("post_rst", 100, 27, 0, 127, 127, 0);
    check_stats("post_rst", 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
